// File: rtl/sequential_arithmetic_unit_pkg.sv
// Shared types for the execute-stage arithmetic unit: operation encoding,
// controller states and small operation-class helpers.
package common;

    localparam int REGISTER_WIDTH = 32;

    typedef enum logic [4:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
    } alu_op_t;

    // State literals carry a prefix because MUL/DIV already name operations.
    typedef enum logic [1:0] {
        ST_IDLE, ST_MUL, ST_DIV, ST_DONE
    } sau_state_t;

    function automatic logic is_mul_op(input alu_op_t op);
        return op inside {MUL, MULH, MULHSU, MULHU};
    endfunction

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic is_rem_op(input alu_op_t op);
        return op inside {REM, REMU};
    endfunction

    // Operand A is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input alu_op_t op);
        return op inside {MULH, MULHSU, DIV, REM};
    endfunction

    // Operand B is treated as signed for MULH, DIV and REM.
    function automatic logic b_is_signed(input alu_op_t op);
        return op inside {MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/sequential_arithmetic_unit_divider.sv
// Restoring unsigned divider, one quotient bit per cycle. Operands are
// latched on start; done is high during the final iteration, with
// quotient/remainder showing the values that iteration produces.
module iterative_divider
    import common::*;
#(
    parameter int WIDTH = REGISTER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] ITER_START = CW'(WIDTH);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic             active;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, divisor_q};
        take     = ~diff[WIDTH];
        rem_next = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], take};
    end

    assign done      = active && (count == ONE);
    assign quotient  = quo_next;
    assign remainder = rem_next;

    // Iteration registers; the dividend is shifted out of the quotient register.
    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            count     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
        end else if (abort) begin
            active <= 1'b0;
        end else if (start) begin
            active    <= 1'b1;
            count     <= ITER_START;
            rem_q     <= '0;
            quo_q     <= dividend;
            divisor_q <= divisor;
        end else if (active) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count - ONE;
            if (count == ONE) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sequential_arithmetic_unit.sv
// Execute-stage arithmetic unit: single-cycle RV32I base ops plus iterative
// M-extension multiply/divide behind valid/ready handshakes.
module sequential_arithmetic_unit
    import common::*;
#(
    parameter int WIDTH = REGISTER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0]    ITER_START = CW'(WIDTH);
    localparam logic [CW-1:0]    ONE        = CW'(1);
    localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    sau_state_t state;
    sau_state_t next_state;
    sau_state_t dispatch_state;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] base_result;
    logic [WIDTH-1:0] special_result;
    logic [WIDTH-1:0] accept_result;
    logic             div_by_zero;
    logic             overflow;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic [WIDTH-1:0]   mul_a;
    logic [2*WIDTH-1:0] product;
    logic [CW-1:0]      iter_cnt;
    logic               neg_q;
    logic               rem_neg_q;
    logic               high_q;
    logic               rem_sel_q;
    logic [WIDTH-1:0]   result_q;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] product_step;
    logic [2*WIDTH-1:0] product_final;
    logic [WIDTH-1:0]   mul_result;

    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic [WIDTH-1:0] div_result;

    assign accept = in_valid && in_ready;
    assign shamt  = operand_b[SHW-1:0];

    // Single-cycle base ALU on the raw operands.
    always_comb begin
        base_result = '0;
        case (op)
            ADD:     base_result = operand_a + operand_b;
            SUB:     base_result = operand_a - operand_b;
            SLL:     base_result = operand_a << shamt;
            SLT:     base_result = WIDTH'($signed(operand_a) < $signed(operand_b));
            SLTU:    base_result = WIDTH'(operand_a < operand_b);
            XOR:     base_result = operand_a ^ operand_b;
            SRL:     base_result = operand_a >> shamt;
            SRA:     base_result = $unsigned($signed(operand_a) >>> shamt);
            OR:      base_result = operand_a | operand_b;
            AND:     base_result = operand_a & operand_b;
            default: base_result = '0;
        endcase
    end

    // Sign stripping and the divide special cases resolved at accept.
    always_comb begin
        a_neg       = a_is_signed(op) && operand_a[WIDTH-1];
        b_neg       = b_is_signed(op) && operand_b[WIDTH-1];
        a_mag       = a_neg ? -operand_a : operand_a;
        b_mag       = b_neg ? -operand_b : operand_b;
        div_by_zero = (operand_b == '0);
        overflow    = (op == DIV || op == REM) && (operand_a == MOST_NEG) && (operand_b == '1);
        if (is_rem_op(op)) begin
            special_result = div_by_zero ? operand_a : '0;
        end else begin
            special_result = div_by_zero ? '1 : MOST_NEG;
        end
        accept_result = is_div_op(op) ? special_result : base_result;
        if (is_mul_op(op)) begin
            dispatch_state = ST_MUL;
        end else if (is_div_op(op) && !div_by_zero && !overflow) begin
            dispatch_state = ST_DIV;
        end else begin
            dispatch_state = ST_DONE;
        end
    end

    // One shift-add multiply step plus sign fix-up of the finished product.
    always_comb begin
        mul_sum       = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, (product[0] ? mul_a : {WIDTH{1'b0}})};
        product_step  = {mul_sum, product[WIDTH-1:1]};
        product_final = neg_q ? -product_step : product_step;
        mul_result    = high_q ? product_final[2*WIDTH-1:WIDTH] : product_final[WIDTH-1:0];
    end

    // Restore signs of the unsigned divider outputs.
    always_comb begin
        if (rem_sel_q) begin
            div_result = rem_neg_q ? -div_remainder : div_remainder;
        end else begin
            div_result = neg_q ? -div_quotient : div_quotient;
        end
    end

    assign div_start = accept && (dispatch_state == ST_DIV);

    iterative_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .abort     (flush),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // Controller state register; flush and reset both return to idle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; DONE with out_ready behaves like IDLE for a new op.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = dispatch_state;
            ST_MUL:  if (iter_cnt == ONE) next_state = ST_DONE;
            ST_DIV:  if (div_done) next_state = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    next_state = accept ? dispatch_state : ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: in_ready = !flush && !reset;
            ST_MUL:  busy = 1'b1;
            ST_DIV:  busy = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !flush && !reset;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign result = result_q;

    // Operand capture, multiply iteration and the registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a     <= '0;
            product   <= '0;
            iter_cnt  <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            high_q    <= 1'b0;
            rem_sel_q <= 1'b0;
            result_q  <= '0;
        end else if (!flush) begin
            if (accept) begin
                mul_a     <= a_mag;
                product   <= {{WIDTH{1'b0}}, b_mag};
                iter_cnt  <= ITER_START;
                neg_q     <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
                high_q    <= (op != MUL);
                rem_sel_q <= is_rem_op(op);
                if (dispatch_state == ST_DONE) begin
                    result_q <= accept_result;
                end
            end else if (state == ST_MUL) begin
                product  <= product_step;
                iter_cnt <= iter_cnt - ONE;
                if (iter_cnt == ONE) begin
                    result_q <= mul_result;
                end
            end else if (state == ST_DIV && div_done) begin
                result_q <= div_result;
            end
        end
    end

endmodule

// File: tb/tb_sequential_arithmetic_unit.sv
// Directed self-checking bench for sequential_arithmetic_unit (WIDTH=32).
module tb_sequential_arithmetic_unit;
    import common::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    alu_op_t     op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    sequential_arithmetic_unit #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input alu_op_t o, input logic [31:0] a, input logic [31:0] b);
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = ADD;
        operand_a = '0;
        operand_b = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_base_ops();
        alu_op_t     ops [10] = '{SRA, SLT, SLTU, ADD, SUB, SLL, SRL, XOR, OR, AND};
        logic [31:0] av  [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0,
                                  32'h1, 32'h8000_0000, 32'hF0F0, 32'hF0F0, 32'hF0F0};
        logic [31:0] bv  [10] = '{32'd4, 32'd1, 32'd1, 32'd1, 32'd1, 32'h21, 32'd4, 32'h0FF0, 32'h0FF0, 32'h0FF0};
        logic [31:0] ev  [10] = '{32'hF800_0000, 32'h1, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF,
                                  32'h2, 32'h0800_0000, 32'hFF00, 32'hFFF0, 32'h00F0};
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(ops[i], av[i], bv[i]);
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || result !== ev[i]) begin
                failures++;
                $display("[TB] FAIL base_%s: got valid=%b result=%h expected valid=1 result=%h",
                         ops[i].name(), out_valid, result, ev[i]);
            end
            step();
        end
    endtask

    task automatic test_iterative();
        alu_op_t     ops [8] = '{MULH, MUL, MULHU, MULHSU, DIV, REM, DIVU, REMU};
        logic [31:0] av  [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] bv  [8] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd2, 32'd2, 32'd2, 32'd2};
        logic [31:0] ev  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h2, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h1};
        int bad;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(ops[i], av[i], bv[i]);
            step();
            in_valid = 1'b0;
            bad = 0;
            for (int c = 0; c < 32; c++) begin
                if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
                step();
            end
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("[TB] FAIL busy_window_%s: got %0d bad cycles expected 0", ops[i].name(), bad);
            end
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || result !== ev[i]) begin
                failures++;
                $display("[TB] FAIL iter_%s: got valid=%b busy=%b result=%h expected valid=1 busy=0 result=%h",
                         ops[i].name(), out_valid, busy, result, ev[i]);
            end
            step();
        end
    endtask

    task automatic test_special_cases();
        alu_op_t     ops [4] = '{DIVU, DIV, REM, REMU};
        logic [31:0] av  [4] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'd7};
        logic [31:0] bv  [4] = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ev  [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'd7};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(ops[i], av[i], bv[i]);
            step();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || result !== ev[i]) begin
                failures++;
                $display("[TB] FAIL special_%s: got valid=%b busy=%b result=%h expected valid=1 busy=0 result=%h",
                         ops[i].name(), out_valid, busy, result, ev[i]);
            end
            step();
        end
    endtask

    task automatic test_hold();
        int bad;
        out_ready = 1'b0;
        apply_stimulus(ADD, 32'd1, 32'd2);
        step();
        in_valid = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL hold_result: got %0d bad cycles (last valid=%b result=%h in_ready=%b) expected 0",
                     bad, out_valid, result, in_ready);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL hold_release: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int bad_ready;
        int bad_result;
        bad_ready  = 0;
        bad_result = 0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(ADD, 32'(i), 32'd100);
            #1;
            if (in_ready !== 1'b1) bad_ready++;
            step();
            if (out_valid !== 1'b1 || result !== 32'(100 + i)) bad_result++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad_ready !== 0) begin failures++; $display("[TB] FAIL b2b_in_ready: got %0d stalls expected 0", bad_ready); end
        checks++;
        if (bad_result !== 0) begin failures++; $display("[TB] FAIL b2b_results: got %0d wrong cycles expected 0", bad_result); end
        step();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain: got valid=%b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        int spurious;
        apply_stimulus(DIVU, 32'd100, 32'd7);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) step();
        flush = 1'b1;
        apply_stimulus(ADD, 32'd1, 32'd1);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_idle: got valid=%b busy=%b expected valid=0 busy=0", out_valid, busy);
        end
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid !== 1'b0) spurious++;
            step();
        end
        checks++;
        if (spurious !== 0) begin failures++; $display("[TB] FAIL flush_no_result: got %0d valid cycles expected 0", spurious); end
        apply_stimulus(DIVU, 32'd100, 32'd7);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 32; c++) step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd14) begin
            failures++;
            $display("[TB] FAIL flush_recover: got valid=%b result=%h expected valid=1 result=0000000e", out_valid, result);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        apply_stimulus(MUL, 32'd5, 32'd6);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) step();
        reset = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_mul: got valid=%b busy=%b result=%h in_ready=%b expected 0 0 00000000 0",
                     out_valid, busy, result, in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_mid_ready: got %b expected 1", in_ready); end
        apply_stimulus(MUL, 32'd5, 32'd6);
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 32; c++) step();
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd30) begin
            failures++;
            $display("[TB] FAIL reset_recover: got valid=%b result=%h expected valid=1 result=0000001e", out_valid, result);
        end
        step();
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_base_ops();
        test_iterative();
        test_special_cases();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
